fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that owns the program counter and issues word fetches to instruction memory over a req/gnt/rvalid interface.
- Presents each fetched instruction with its PC to the IF/ID pipeline register through a valid/ready handshake.
- Handles control-flow redirects from execute, including discarding responses already in flight.
- At most one memory request is outstanding at any time.

Parameters:
- XLEN, 32, width of PC, address and instruction data.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch address, word aligned.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid; cannot be back-pressured.
- imem_rdata  input  XLEN  fetched instruction.
- redirect_valid  input  1  control-flow redirect.
- redirect_pc  input  XLEN  redirect target.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  downstream accepts; when low, the IF/ID register is stalled.
- if_pc  output  XLEN  PC of the presented instruction.
- if_instr  output  XLEN  presented instruction.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc_q = RESET_PC; FSM = S_REQ.
  - if_valid = 0, if_pc = 0, if_instr = 32'h00000013 (NOP).
  - imem_req = 0 while rst is high.
  - Reset mid-transaction abandons the transaction; no response is tracked after reset.
- imem_addr = {pc_q[XLEN-1:2], 2'b00} in every cycle.
- One-entry output buffer (if_valid, if_pc, if_instr):
  - Cleared when if_valid && if_ready.
  - Contents hold stable while if_valid && !if_ready.
- FSM, with no redirect in the cycle:
  - S_REQ: imem_req = !if_valid || if_ready. If imem_req && imem_gnt, record req_pc = pc_q and go to S_WAIT.
  - S_WAIT: imem_req = 0. On imem_rvalid: load the buffer (if_valid = 1, if_pc = req_pc, if_instr = imem_rdata), set pc_q = pc_q + 4, go to S_REQ. A request is issued only into an empty-or-draining buffer, so the buffer is always free when the response arrives.
  - S_DROP: imem_req = 0. On imem_rvalid: discard the data and go to S_REQ.
- Redirect (redirect_valid = 1) has priority over all other updates in that cycle:
  - pc_q <= {redirect_pc[XLEN-1:2], 2'b00}.
  - The buffer is cleared (if_valid = 0), even if if_ready is high that cycle.
  - S_REQ with imem_gnt the same cycle: go to S_DROP (the granted request's response is discarded).
  - S_REQ without imem_gnt: the request is withdrawn; next cycle imem_req reasserts with the new address. The memory interface permits withdrawal.
  - S_WAIT without imem_rvalid: go to S_DROP.
  - S_WAIT with imem_rvalid: drop the response; go to S_REQ.
  - S_DROP without imem_rvalid: stay in S_DROP with the pc updated.
  - S_DROP with imem_rvalid: go to S_REQ.
- PC arithmetic is modulo 2^XLEN: 32'hFFFFFFFC + 4 wraps to 32'h00000000.
- imem_gnt and imem_rvalid are ignored outside the states listed above.
- Throughput: with zero-wait memory (gnt in the request cycle, rvalid the next cycle) and if_ready held high, one instruction every 2 cycles.

Test Plan:
- Reset then zero-wait memory, if_ready = 1: fetches 0x0, 0x4, 0x8; if_pc sequence 0x0, 0x4, 0x8 with matching if_instr; if_valid first high in the 3rd cycle after reset release.
- if_ready = 0 for 5 cycles while if_valid = 1 at PC 0x4: if_pc/if_instr stay stable, imem_req = 0; after if_ready rises, the next request goes to 0x8.
- redirect_valid with redirect_pc = 0x100 while in S_WAIT for 0x8, then rvalid arrives 2 cycles later with 0xDEADBEEF: data is dropped and never presented; the next presented instruction has if_pc = 0x100.
- redirect_valid in the same cycle as imem_gnt for 0xC, target 0x203: response for 0xC is dropped; next fetch address is 0x200.
- Redirect to 0xFFFFFFFC: the presented instruction is at 0xFFFFFFFC, and the following fetch address is 0x00000000.
- Assert rst while in S_WAIT: if_valid = 0 immediately (asynchronously), imem_req = 0; after release, the first fetch address is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches
// and presents fetched instructions to decode through a one-entry buffer.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [XLEN-1:0] NOP       = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            valid_d;
  logic [XLEN-1:0] if_pc_d, if_instr_d;
  logic            req_c;

  // Next-state, PC and output-buffer update; redirect overrides everything last.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    valid_d    = if_valid;
    if_pc_d    = if_pc;
    if_instr_d = if_instr;
    req_c      = 1'b0;

    if (if_valid && if_ready) valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
        req_c = !if_valid || if_ready;
        if (req_c && imem_gnt) begin
          req_pc_d = pc_q;
          state_d  = redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          if (!redirect_valid) begin
            valid_d    = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rdata;
            pc_d       = pc_q + PC_STEP;
          end
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      valid_d = 1'b0;
      pc_d    = redirect_pc & ALIGN_MSK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= {XLEN{1'b0}};
      if_instr <= NOP;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      if_valid <= valid_d;
      if_pc    <= if_pc_d;
      if_instr <= if_instr_d;
    end
  end

  // Request is a function of state and downstream readiness; forced low in reset.
  assign imem_req  = req_c && !rst;
  assign imem_addr = pc_q & ALIGN_MSK;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level memory model plus a
// program-order PC/epoch scoreboard checks every fetch and every delivery.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus knobs (percentages / max latency)
  int p_gnt, max_lat, p_ready, p_redir;

  // Memory model: one tracked transaction
  bit          outstanding;
  logic [31:0] pend_addr, pend_salt;
  int          lat;

  // Reference: next instruction in program order and current redirect epoch
  logic [31:0] exp_pc, salt, last_pc;
  int          accepted, first_valid, cyc;
  bit          wrap_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else                        t = $urandom & 32'h0000_FFFF;
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'h0000_0013);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    outstanding = 1'b0;
    exp_pc = RESET_PC;
    salt = $urandom;
    first_valid = -1;
    cyc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: drive inputs after negedge, check, then advance the models.
  task automatic cycle(input bit force_redir, input logic [31:0] force_tgt);
    bit resp;
    @(negedge clk);
    resp = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (outstanding) begin
      if (lat == 0) begin
        resp = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = word_of(pend_addr, pend_salt);
      end else begin
        lat--;
      end
    end
    if_ready = ($urandom_range(99) < p_ready);
    redirect_valid = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc = force_redir ? force_tgt : rand_target();
    #1;
    imem_gnt = imem_req && ($urandom_range(99) < p_gnt);
    #1;

    if (imem_req) begin
      check("single_outstanding", 32'(outstanding), 32'd0);
      check("fetch_addr", imem_addr, exp_pc + (if_valid ? 32'd4 : 32'd0));
    end
    if (resp) outstanding = 1'b0;
    if (if_valid && first_valid < 0) first_valid = cyc;
    if (if_valid && if_ready && !redirect_valid) begin
      check("deliver_pc", if_pc, exp_pc);
      check("deliver_instr", if_instr, word_of(exp_pc, salt));
      if (accepted > 0 && last_pc == 32'hFFFF_FFFC && exp_pc == 32'h0) wrap_seen = 1'b1;
      last_pc = exp_pc;
      exp_pc = exp_pc + 32'd4;
      accepted++;
    end
    if (imem_gnt) begin
      outstanding = 1'b1;
      pend_addr = imem_addr;
      pend_salt = salt;
      lat = $urandom_range(max_lat);
    end
    if (redirect_valid) begin
      exp_pc = redirect_pc & ~32'd3;
      salt = $urandom;
    end
    cyc++;
  endtask

  task automatic zero_wait();
    p_gnt = 100; max_lat = 0; p_ready = 100; p_redir = 0;
  endtask

  initial begin
    int base;
    int n;
    accepted = 0; last_pc = '0; wrap_seen = 1'b0; lat = 0;
    pend_addr = '0; pend_salt = '0;
    do_reset();

    // Zero-wait memory, decode always ready: one instruction per two cycles
    zero_wait();
    repeat (20) cycle(1'b0, 32'h0);
    check("first_valid_cycle", 32'(first_valid), 32'd2);
    check("throughput", 32'(accepted), 32'd9);

    // Decode stall, then release
    p_ready = 0;
    repeat (5) cycle(1'b0, 32'h0);
    p_ready = 100;
    repeat (6) cycle(1'b0, 32'h0);

    // Slow memory with redirects hitting the wait and grant windows
    p_gnt = 100; max_lat = 2;
    repeat (3) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h0000_0100);
    repeat (8) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h0000_0203);
    repeat (8) cycle(1'b0, 32'h0);

    // PC wrap at the top of the address space
    zero_wait();
    cycle(1'b1, 32'hFFFF_FFFC);
    repeat (10) cycle(1'b0, 32'h0);
    check("pc_wrap_seen", 32'(wrap_seen), 32'd1);

    // Fully random traffic
    base = accepted;
    p_gnt = 70; max_lat = 3; p_ready = 70; p_redir = 4;
    repeat (3000) cycle(1'b0, 32'h0);
    check("random_progress", 32'(accepted - base > 100), 32'd1);

    // Async reset while a response is outstanding
    p_gnt = 100; max_lat = 3; p_ready = 100; p_redir = 0;
    n = 0;
    while (!(outstanding && lat >= 1) && n < 50) begin
      cycle(1'b0, 32'h0);
      n++;
    end
    check("reach_wait", 32'(outstanding), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(if_valid), 32'd0);
    check("async_rst_req", 32'(imem_req), 32'd0);
    do_reset();
    zero_wait();
    base = accepted;
    repeat (20) cycle(1'b0, 32'h0);
    check("post_rst_throughput", 32'(accepted - base), 32'd9);

    // Async reset while an instruction is held in the buffer
    p_ready = 0;
    n = 0;
    while (!if_valid && n < 20) begin
      cycle(1'b0, 32'h0);
      n++;
    end
    check("buffer_full", 32'(if_valid), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid_full", 32'(if_valid), 32'd0);
    check("async_rst_instr", if_instr, 32'h0000_0013);
    do_reset();
    zero_wait();
    repeat (10) cycle(1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
